// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - execute/decode to writeback bus bundle
interface writeback_regfile_if #(
   parameter int LAT_W = 3
);
   logic             ex_valid;
   logic [31:0]      ex_d;
   logic [1:0]       ex_wr;
   logic [4:0]       ex_rd;
   logic [LAT_W-1:0] ex_lat;
   logic [5:0]       rs_addr;
   logic [5:0]       rt_addr;
   logic [31:0]      rs_data;
   logic [31:0]      rt_data;
   logic [31:0]      ew_d;
   logic [1:0]       ew_rw;
   logic [5:0]       ew_rd;
   logic             stall;
   logic             retired;

   // execute/decode side
   modport master (
      output ex_valid, ex_d, ex_wr, ex_rd, ex_lat, rs_addr, rt_addr,
      input  rs_data, rt_data, ew_d, ew_rw, ew_rd, stall, retired
   );

   // writeback/register-file side
   modport slave (
      input  ex_valid, ex_d, ex_wr, ex_rd, ex_lat, rs_addr, rt_addr,
      output rs_data, rt_data, ew_d, ew_rw, ew_rd, stall, retired
   );
endinterface

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback stage with GPR/FPR banks and latency countdown
module writeback_regfile #(
   parameter int LAT_W = 3,
   parameter int NREG  = 32
) (
   input  logic               clk,
   input  logic               rstn,
   writeback_regfile_if.slave bus
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t           state, state_nxt;
   logic [LAT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       pend_wr, pend_wr_nxt;
   logic [4:0]       pend_rd, pend_rd_nxt;

   logic [31:0]      gpr [NREG];
   logic [31:0]      fpr [NREG];

   logic             commit;
   logic [1:0]       c_wr;
   logic [4:0]       c_rd;
   logic             we_gpr, we_fpr, c_ok;
   logic             stall_c;

   // Next-state: accept or commit in IDLE, count down in WAIT; pending dest comes from the latch in WAIT
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pend_wr_nxt = pend_wr;
      pend_rd_nxt = pend_rd;
      commit      = 1'b0;
      stall_c     = 1'b0;
      c_wr        = bus.ex_wr;
      c_rd        = bus.ex_rd;
      case (state)
         S_IDLE: begin
            if (bus.ex_valid) begin
               if (bus.ex_lat == '0) begin
                  commit = 1'b1;
               end else begin
                  stall_c     = 1'b1;
                  state_nxt   = S_WAIT;
                  cnt_nxt     = bus.ex_lat;
                  pend_wr_nxt = bus.ex_wr;
                  pend_rd_nxt = bus.ex_rd;
               end
            end
         end
         S_WAIT: begin
            stall_c = 1'b1;
            c_wr    = pend_wr;
            c_rd    = pend_rd;
            if (cnt == LAT_W'(1)) begin
               commit    = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt - LAT_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Only real bank writes count as commits; GPR0 and class 00/11 are dropped
   always_comb begin
      we_gpr = commit && (c_wr == 2'b01) && (c_rd != 5'd0);
      we_fpr = commit && (c_wr == 2'b10);
      c_ok   = we_gpr || we_fpr;
   end

   assign bus.stall = stall_c;

   // FSM state, countdown and latched destination
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= S_IDLE;
         cnt     <= '0;
         pend_wr <= 2'b00;
         pend_rd <= 5'd0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         pend_wr <= pend_wr_nxt;
         pend_rd <= pend_rd_nxt;
      end
   end

   // Register banks
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NREG; i++) begin
            gpr[i] <= 32'd0;
            fpr[i] <= 32'd0;
         end
      end else begin
         if (we_gpr) gpr[c_rd] <= bus.ex_d;
         if (we_fpr) fpr[c_rd] <= bus.ex_d;
      end
   end

   // Forwarding tuple; ew_rw marks validity so a stale ew_d/ew_rd is never flagged
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.ew_d    <= 32'd0;
         bus.ew_rw   <= 2'b00;
         bus.ew_rd   <= 6'd0;
         bus.retired <= 1'b0;
      end else begin
         bus.retired <= c_ok;
         bus.ew_rw   <= c_ok ? c_wr : 2'b00;
         if (commit) begin
            bus.ew_d  <= bus.ex_d;
            bus.ew_rd <= {c_wr == 2'b10, c_rd};
         end
      end
   end

   function automatic logic [31:0] read_port(input logic [5:0] a);
      logic [31:0] r;
      if (!a[5] && a[4:0] == 5'd0)
         r = 32'd0;
      else if ((we_gpr && !a[5] && a[4:0] == c_rd) || (we_fpr && a[5] && a[4:0] == c_rd))
         r = bus.ex_d;
      else if (a[5])
         r = fpr[a[4:0]];
      else
         r = gpr[a[4:0]];
      return r;
   endfunction

   // Decode read ports with write-through bypass of the commit landing this edge
   always_comb begin
      bus.rs_data = read_port(bus.rs_addr);
      bus.rt_data = read_port(bus.rt_addr);
   end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - directed self-checking bench for writeback_regfile
module tb_writeback_regfile;
   logic clk;
   logic rstn;
   int   n_checks;
   int   n_fail;

   writeback_regfile_if #(.LAT_W(3)) bus ();

   writeback_regfile #(.LAT_W(3), .NREG(32)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic       held_v;
   logic [1:0] held_wr;
   logic [4:0] held_rd;

   // upstream must keep the destination stable for the whole stall window
   always @(negedge clk) begin
      #2;
      if (rstn && bus.stall) begin
         if (held_v) begin
            n_checks++;
            if (bus.ex_wr !== held_wr || bus.ex_rd !== held_rd) begin
               n_fail++;
               $display("FAIL hold_during_wait: wr/rd %0h/%0h, required %0h/%0h",
                        bus.ex_wr, bus.ex_rd, held_wr, held_rd);
            end
         end
         held_v  = 1'b1;
         held_wr = bus.ex_wr;
         held_rd = bus.ex_rd;
      end else begin
         held_v = 1'b0;
      end
   end

   task automatic idle_inputs();
      bus.ex_valid = 1'b0;
      bus.ex_d     = 32'd0;
      bus.ex_wr    = 2'b00;
      bus.ex_rd    = 5'd0;
      bus.ex_lat   = 3'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.rs_addr = 6'd0;
      bus.rt_addr = 6'd0;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 64; i++) begin
         bus.rs_addr = 6'(i);
         bus.rt_addr = 6'(63 - i);
         #1;
         n_checks++;
         if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_read addr %0d: rs %h rt %h, required 0", i, bus.rs_data, bus.rt_data);
         end
      end
      n_checks++;
      if (bus.ew_rw !== 2'b00 || bus.stall !== 1'b0 || bus.retired !== 1'b0 ||
          bus.ew_d !== 32'd0 || bus.ew_rd !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: ew_rw %b stall %b retired %b ew_d %h ew_rd %h, required all 0",
                  bus.ew_rw, bus.stall, bus.retired, bus.ew_d, bus.ew_rd);
      end
   endtask

   task automatic test_zero_lat();
      @(negedge clk);
      bus.ex_valid = 1'b1; bus.ex_wr = 2'b01; bus.ex_rd = 5'd5;
      bus.ex_d = 32'h12345678; bus.ex_lat = 3'd0;
      bus.rs_addr = 6'h05;
      #1;
      n_checks++;
      if (bus.rs_data !== 32'h12345678 || bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_lat_bypass: rs %h stall %b, required 12345678 0", bus.rs_data, bus.stall);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      n_checks++;
      if (bus.ew_rw !== 2'b01 || bus.ew_rd !== 6'h05 || bus.retired !== 1'b1 || bus.ew_d !== 32'h12345678) begin
         n_fail++;
         $display("FAIL zero_lat_commit: ew_rw %b ew_rd %h retired %b ew_d %h, required 01 05 1 12345678",
                  bus.ew_rw, bus.ew_rd, bus.retired, bus.ew_d);
      end
      n_checks++;
      if (bus.rs_data !== 32'h12345678) begin
         n_fail++;
         $display("FAIL zero_lat_read: rs %h, required 12345678", bus.rs_data);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.ew_rw !== 2'b00 || bus.retired !== 1'b0 || bus.ew_rd !== 6'h05) begin
         n_fail++;
         $display("FAIL zero_lat_idle: ew_rw %b retired %b ew_rd %h, required 00 0 05",
                  bus.ew_rw, bus.retired, bus.ew_rd);
      end
   endtask

   task automatic test_reg_zero();
      @(negedge clk);
      bus.ex_valid = 1'b1; bus.ex_wr = 2'b01; bus.ex_rd = 5'd0;
      bus.ex_d = 32'hFFFFFFFF; bus.ex_lat = 3'd0;
      bus.rs_addr = 6'h00;
      #1;
      n_checks++;
      if (bus.rs_data !== 32'd0) begin
         n_fail++;
         $display("FAIL gpr0_bypass: rs %h, required 0", bus.rs_data);
      end
      @(negedge clk);
      bus.ex_wr = 2'b10; bus.rt_addr = 6'h20;
      #1;
      n_checks++;
      if (bus.ew_rw !== 2'b00 || bus.retired !== 1'b0 || bus.rs_data !== 32'd0) begin
         n_fail++;
         $display("FAIL gpr0_write: ew_rw %b retired %b rs %h, required 00 0 0",
                  bus.ew_rw, bus.retired, bus.rs_data);
      end
      n_checks++;
      if (bus.rt_data !== 32'hFFFFFFFF) begin
         n_fail++;
         $display("FAIL fpr0_bypass: rt %h, required ffffffff", bus.rt_data);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      n_checks++;
      if (bus.ew_rw !== 2'b10 || bus.ew_rd !== 6'h20 || bus.retired !== 1'b1 ||
          bus.rt_data !== 32'hFFFFFFFF || bus.rs_data !== 32'd0) begin
         n_fail++;
         $display("FAIL fpr0_write: ew_rw %b ew_rd %h retired %b rt %h rs %h, required 10 20 1 ffffffff 0",
                  bus.ew_rw, bus.ew_rd, bus.retired, bus.rt_data, bus.rs_data);
      end
   endtask

   task automatic test_multi_cycle();
      int stalls;
      int pulses;
      stalls = 0;
      pulses = 0;
      @(negedge clk);
      bus.rt_addr = 6'h27;
      bus.ex_valid = 1'b1; bus.ex_wr = 2'b10; bus.ex_rd = 5'd7; bus.ex_lat = 3'd3;
      for (int c = 0; c < 4; c++) begin
         bus.ex_d = (c < 3) ? 32'h0000DEAD : 32'h3F800000;
         #1;
         if (bus.stall === 1'b1) stalls++;
         if (bus.retired === 1'b1) pulses++;
         n_checks++;
         if (bus.rt_data !== ((c < 3) ? 32'd0 : 32'h3F800000)) begin
            n_fail++;
            $display("FAIL multi_read cycle %0d: rt %h", c, bus.rt_data);
         end
         @(negedge clk);
      end
      idle_inputs();
      #1;
      if (bus.stall === 1'b1) stalls++;
      if (bus.retired === 1'b1) pulses++;
      n_checks++;
      if (bus.ew_rw !== 2'b10 || bus.ew_rd !== 6'h27 || bus.ew_d !== 32'h3F800000 ||
          bus.retired !== 1'b1 || bus.rt_data !== 32'h3F800000) begin
         n_fail++;
         $display("FAIL multi_commit: ew_rw %b ew_rd %h ew_d %h retired %b rt %h, required 10 27 3f800000 1 3f800000",
                  bus.ew_rw, bus.ew_rd, bus.ew_d, bus.retired, bus.rt_data);
      end
      repeat (2) begin
         @(negedge clk);
         #1;
         if (bus.stall === 1'b1) stalls++;
         if (bus.retired === 1'b1) pulses++;
      end
      n_checks++;
      if (stalls != 4 || pulses != 1) begin
         n_fail++;
         $display("FAIL multi_counts: stall cycles %0d retired pulses %0d, required 4 1", stalls, pulses);
      end
   endtask

   task automatic test_reset_mid_wait();
      int pulses;
      pulses = 0;
      @(negedge clk);
      bus.ex_valid = 1'b1; bus.ex_wr = 2'b01; bus.ex_rd = 5'd9;
      bus.ex_d = 32'hAAAA5555; bus.ex_lat = 3'd5;
      bus.rs_addr = 6'h09; bus.rt_addr = 6'h05;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (bus.stall !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_wait_pre: stall %b, required 1", bus.stall);
      end
      rstn = 1'b0;
      bus.ex_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wait_async: stall %b, required 0", bus.stall);
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         #1;
         if (bus.retired === 1'b1 || bus.stall !== 1'b0) pulses++;
      end
      n_checks++;
      if (pulses != 0 || bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_wait_discard: bad cycles %0d gpr9 %h gpr5 %h, required 0 0 0",
                  pulses, bus.rs_data, bus.rt_data);
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k > 1) begin
            #1;
            n_checks++;
            if (bus.retired !== 1'b1 || bus.ew_rw !== 2'b01 || bus.ew_rd !== 6'(k - 1) ||
                bus.ew_d !== 32'(k - 1)) begin
               n_fail++;
               $display("FAIL b2b_commit %0d: retired %b ew_rw %b ew_rd %h ew_d %h", k - 1,
                        bus.retired, bus.ew_rw, bus.ew_rd, bus.ew_d);
            end
         end
         if (k < 4) begin
            bus.ex_valid = 1'b1; bus.ex_wr = 2'b01; bus.ex_rd = 5'(k);
            bus.ex_d = 32'(k); bus.ex_lat = 3'd0;
            #1;
            n_checks++;
            if (bus.stall !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_stall %0d: stall %b, required 0", k, bus.stall);
            end
         end else begin
            idle_inputs();
         end
      end
      bus.rs_addr = 6'h01; bus.rt_addr = 6'h03;
      #1;
      n_checks++;
      if (bus.rs_data !== 32'd1 || bus.rt_data !== 32'd3) begin
         n_fail++;
         $display("FAIL b2b_read13: rs %h rt %h, required 1 3", bus.rs_data, bus.rt_data);
      end
      bus.rs_addr = 6'h02; bus.rt_addr = 6'h02;
      #1;
      n_checks++;
      if (bus.rs_data !== 32'd2 || bus.rt_data !== 32'd2) begin
         n_fail++;
         $display("FAIL b2b_read2: rs %h rt %h, required 2 2", bus.rs_data, bus.rt_data);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      held_v   = 1'b0;
      held_wr  = 2'b00;
      held_rd  = 5'd0;
      rstn     = 1'b1;
      test_reset();
      test_zero_lat();
      test_reg_zero();
      test_multi_cycle();
      test_reset_mid_wait();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Stage directly downstream of execute.
- Accepts execute's result, destination and latency class, and commits results to the integer (GPR) and float (FPR) register banks.
- For multi-cycle units (MUL, DIV, FADD/FSUB pipelines), counts down the latency while holding a stall, then samples the result.
- Also serves the decode-stage read ports and drives the registered ew_d/ew_rw/ew_rd forwarding tuple back into execute.

Parameters:
- LAT_W, 3, width of the latency field; maximum latency is 2^LAT_W-1 cycles.
- NREG, 32, registers per bank.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- ex_valid  in  1  execute presents a completing instruction this cycle
- ex_d  in  32  execute result; must be held stable while stall=1
- ex_wr  in  2  write class: 00 none, 01 GPR, 10 FPR, 11 treated as none
- ex_rd  in  5  destination index
- ex_lat  in  LAT_W  extra cycles until ex_d is valid; 0 means valid now
- rs_addr  in  6  read port A: [5] bank (0 GPR, 1 FPR), [4:0] index
- rt_addr  in  6  read port B, same encoding
- rs_data  out  32  read data A, combinational
- rt_data  out  32  read data B, combinational
- ew_d  out  32  last committed value, registered
- ew_rw  out  2  class of last commit: 00 none, 01 GPR, 10 FPR
- ew_rd  out  6  {bank, index} of last commit
- stall  out  1  upstream must hold the instruction and ex_d
- retired  out  1  one-cycle pulse per commit

Behaviour:
- Reset (rstn low, async): all 64 registers 0, ew_d=0, ew_rw=00, ew_rd=0, retired=0, latency counter 0, pending flag 0. Combinational outputs follow from these values.
- Reset asserted mid-countdown: the pending write is discarded. After release, stall=0 unless ex_valid with ex_lat≠0 is present.
- GPR index 0 is hardwired zero:
  - A write to it is dropped: no array update, ew_rw=00, retired=0.
  - FPR index 0 is a normal register.

Zero-latency path (ex_valid=1, ex_lat=0, stall=0):
- At the next edge, write ex_d to the bank/index selected by ex_wr/ex_rd.
- ew_d<=ex_d, ew_rw<=ex_wr, ew_rd<={ex_wr==10, ex_rd}, retired<=1.
- If ex_wr is 00 or 11: no write, ew_rw<=00, retired<=0, and ew_d/ew_rd still update.

Multi-cycle path (ex_valid=1, ex_lat=N>0):
- States: IDLE, WAIT.
- Acceptance cycle (IDLE): stall=1 combinationally. At the edge, latch ex_wr and ex_rd, cnt<=N, go to WAIT.
- WAIT: stall=1.
  - cnt>1: cnt-- each edge.
  - cnt==1: sample ex_d at this edge and commit as in the zero-latency path (ew_*, retired). cnt<=0, return to IDLE.
- The commit lands at the N-th edge after the acceptance edge; stall is high for N+1 cycles total.
- In WAIT, ex_valid/ex_lat are ignored and only ex_d is sampled. Upstream holds the instruction, so it is not re-accepted. A bench assertion flags any change of ex_wr/ex_rd during WAIT.

Other rules:
- stall = (IDLE && ex_valid && ex_lat≠0) || WAIT.
- Read ports:
  - rs_data/rt_data = array[addr], with GPR0 reading 0.
  - Write-through bypass: if a commit to the same {bank, index} happens at the coming edge, the port returns the value being written (ex_d).
- Both read ports are independent; both may address the same register.
- ew_rw=00 in any cycle without a commit. ew_d/ew_rd hold their last values, so a stale tuple is never flagged valid.
- Back-to-back zero-latency commits: one per cycle, no bubble.
- retired is high exactly in the cycle after each commit edge.

Test Plan:
- Reset, then read all 64 addresses → all 0. ew_rw=00, stall=0.
- ex_valid, ex_wr=01, ex_rd=5, ex_d=0x12345678, ex_lat=0 → next cycle ew_rw=01, ew_rd=0x05, retired=1; rs_addr=0x05 reads 0x12345678. In the same cycle as the write, rs_addr=0x05 already returns 0x12345678 via bypass.
- Write 0xFFFFFFFF to GPR0, then FPR0 (ex_wr=10) → GPR0 reads 0 with ew_rw=00; FPR0 (addr 0x20) reads 0xFFFFFFFF with ew_rw=10, ew_rd=0x20.
- ex_lat=3, ex_wr=10, ex_rd=7:
  - ex_d=0xDEAD for the first 3 cycles, 0x3F800000 in the cycle with cnt==1.
  - Required: stall high 4 cycles; FPR7=0x3F800000; exactly one retired pulse.
- Assert rstn low in WAIT after a lat=5 acceptance → pending write discarded, target still 0, stall=0 after release.
- Three consecutive lat=0 commits to GPR1, 2, 3 (values 1, 2, 3) → three retired pulses on consecutive cycles, ew_rd sequence 1, 2, 3, no stall.
